mix_bist_ctrl: RTL and testbench
================================

// Module: mix_bist_ctrl
// PURPOSE
//  Built-in self-test wrapper stage for the mix combinational netlist.
//  A Galois LFSR drives mix's inputs {G1,G2,G3,G4,G5[2:0]} through pat_o.
//  A MISR compacts the packed mix outputs, returned on rsp_i, over NPAT cycles.
//  At the end of the run it compares the signature to GOLDEN and flags pass/fail.
// PARAMETERS
//  PAT_W    7         pattern width; pat_o = {G1,G2,G3,G4,G5[2:0]}, MSB = G1
//  RSP_W    16        response width; integrator packs mix outputs, RSP_W <= MISR_W
//  MISR_W   16        signature register width
//  NPAT     100       patterns applied per run, >= 1
//  LFSR_POLY 7'h60    Galois feedback mask for the pattern LFSR
//  LFSR_SEED 7'h01    LFSR value on the first RUN cycle; must be nonzero
//  MISR_POLY 16'hB400 Galois feedback mask for the MISR
//  GOLDEN   16'h0000  expected final signature
// PORTS
//  CK      in   1       clock, rising edge
//  RST     in   1       asynchronous reset, active high
//  start   in   1       1-cycle request; honoured only in IDLE or DONE
//  abort   in   1       in RUN: return to IDLE, discard signature
//  rsp_i   in   RSP_W   mix response for the current pat_o (combinational path)
//  pat_o   out  PAT_W   pattern to mix, registered
//  busy    out  1       high in RUN
//  done    out  1       high in DONE
//  pass    out  1       valid when done; 1 iff sig_o == GOLDEN
//  sig_o   out  MISR_W  current MISR contents
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; pat_o, sig_o and count = 0; busy, done, pass = 0.
//  States: IDLE, RUN, DONE. All outputs are registered or decoded from state.
//  Update rules:
//   - LFSR next = (s>>1) ^ (s[0] ? LFSR_POLY : 0).
//   - MISR next = (m>>1) ^ (m[0] ? MISR_POLY : 0) ^ zero_ext(rsp_i).
//  IDLE:
//   - pat_o = 0.
//   - On start: pat_o <= LFSR_SEED, sig_o <= 0, count <= 0; go to RUN.
//  RUN, each cycle k = 0..NPAT-1:
//   - pat_o holds pattern s_k; rsp_i must settle within the same cycle.
//   - At the clock edge, the MISR absorbs rsp_i and the LFSR advances.
//   - count increments.
//   - When count == NPAT-1: capture final MISR, pat_o <= 0, go to DONE.
//   - A run lasts exactly NPAT cycles from the cycle after start; busy is high for all of them.
//  DONE:
//   - done = 1; pass = (sig_o == GOLDEN); sig_o frozen.
//   - On start: restart exactly as from IDLE (the signature is cleared).
//  Abort:
//   - In RUN: next state IDLE, pat_o <= 0, sig_o <= 0; done stays 0.
//   - Ignored in IDLE and DONE.
//  Collisions and edge cases:
//   - start during RUN is ignored.
//   - start and abort together in RUN: abort wins.
//   - LFSR wraps after 2^PAT_W-1 states with no special handling; the zero state is never reached.
//   - count width = clog2(NPAT+1); no overflow is possible.
//   - NPAT == 1: RUN lasts one cycle.
//  Reset mid-run: the signature is lost; a fresh start is required.
// TESTING
//  1 Reset, NPAT=4, start at t0 -> pat_o = 01,60,30,18 in cycles t1..t4; DONE at t5; pat_o=0.
//  2 rsp_i tied 16'h0001, NPAT=2, start -> sig_o = 16'h0001 then 16'hB401; pass=1 iff GOLDEN=16'hB401.
//  3 rsp_i tied 0, NPAT=100 -> sig_o = 0; done=1 after 100 busy cycles; pass=1 with GOLDEN=0.
//  4 abort in RUN cycle 2 (and again together with start) -> next cycle IDLE, busy=0, done=0, sig_o=0.
//  5 RST pulsed mid-RUN, asynchronously between edges -> outputs 0 immediately; start -> sequence restarts at 01.
//  6 Closed loop with mix -> sig_o matches reference model (LFSR -> mix eval -> MISR); start in DONE reruns identically.

Source files
------------

// File: rtl/mix_bist_if.sv
// BIST handshake and data bundle between the mix pattern/response harness and mix_bist_ctrl.
interface mix_bist_if #(
  parameter int PAT_W  = 7,
  parameter int RSP_W  = 16,
  parameter int MISR_W = 16
);
  logic              start;
  logic              abort;
  logic [RSP_W-1:0]  rsp_i;
  logic [PAT_W-1:0]  pat_o;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] sig_o;

  modport master (output start, abort, rsp_i, input pat_o, busy, done, pass, sig_o);
  modport slave  (input start, abort, rsp_i, output pat_o, busy, done, pass, sig_o);
endinterface

// File: rtl/mix_bist_ctrl.sv
// BIST controller for the mix netlist: Galois LFSR pattern source, Galois MISR
// response compactor, and a three-state run sequencer with golden-signature check.
module mix_bist_ctrl #(
  parameter int                PAT_W     = 7,
  parameter int                RSP_W     = 16,
  parameter int                MISR_W    = 16,
  parameter int                NPAT      = 100,
  parameter logic [PAT_W-1:0]  LFSR_POLY = 7'h60,
  parameter logic [PAT_W-1:0]  LFSR_SEED = 7'h01,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
  parameter logic [MISR_W-1:0] GOLDEN    = 16'h0000
) (
  input  logic     clk,
  input  logic     rst,
  mix_bist_if.slave bus
);

  localparam int CNT_W = $clog2(NPAT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NPAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [PAT_W-1:0]  pat_q, pat_nxt;
  logic [MISR_W-1:0] sig_q, sig_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;

  function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [RSP_W-1:0]  r);
    return (m >> 1) ^ (m[0] ? MISR_POLY : '0) ^ MISR_W'(r);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pat_q <= '0;
      sig_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      pat_q <= pat_nxt;
      sig_q <= sig_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat_q;
    sig_nxt   = sig_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE, DONE: begin
        // A restart from DONE discards the previous signature.
        if (bus.start) begin
          state_nxt = RUN;
          pat_nxt   = LFSR_SEED;
          sig_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          pat_nxt   = '0;
          sig_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          // The last pattern's response is folded in on the same edge that ends the run.
          sig_nxt = misr_step(sig_q, bus.rsp_i);
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_nxt = DONE;
            pat_nxt   = '0;
          end else begin
            pat_nxt   = lfsr_step(pat_q);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        pat_nxt   = '0;
        sig_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.pat_o = pat_q;
  assign bus.sig_o = sig_q;
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.pass  = (state == DONE) && (sig_q == GOLDEN);

endmodule

// File: tb/tb_mix_bist_ctrl.sv
// Directed bench for mix_bist_ctrl: several instances with different run lengths and
// golden signatures, plus a closed loop through a stand-in mix function.
module tb_mix_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mix_bist_if if4 ();
  mix_bist_if if2 ();
  mix_bist_if if100 ();
  mix_bist_if if6 ();

  mix_bist_ctrl #(.NPAT(4))                          u4   (.clk(clk), .rst(rst), .bus(if4));
  mix_bist_ctrl #(.NPAT(2), .GOLDEN(16'hB401))       u2   (.clk(clk), .rst(rst), .bus(if2));
  mix_bist_ctrl #(.NPAT(100))                        u100 (.clk(clk), .rst(rst), .bus(if100));
  mix_bist_ctrl #(.NPAT(20))                         u6   (.clk(clk), .rst(rst), .bus(if6));

  // Stand-in for the mix netlist: any fixed combinational map of the 7-bit pattern.
  function automatic logic [15:0] mix_fn(input logic [6:0] p);
    return {p ^ 7'h55, p[0] & p[1], 8'(p) + 8'd13};
  endfunction

  assign if6.rsp_i = mix_fn(if6.pat_o);

  function automatic logic [6:0] ref_lfsr(input logic [6:0] s);
    logic [6:0] n;
    n = {1'b0, s[6:1]};
    if (s[0]) n = n ^ 7'h60;
    return n;
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] m, input logic [15:0] r);
    logic [15:0] n;
    n = {1'b0, m[15:1]};
    if (m[0]) n = n ^ 16'hB400;
    return n ^ r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    checks++;
    if ({if4.pat_o, if4.busy, if4.done, if4.pass, if4.sig_o} !== 26'd0) begin
      errors++; $display("FAIL reset_u4 got %h exp 0", {if4.pat_o, if4.busy, if4.done, if4.pass, if4.sig_o});
    end
    checks++;
    if ({if2.busy, if2.done, if2.pass, if100.busy, if100.done, if6.busy, if6.done, if6.sig_o} !== 23'd0) begin
      errors++; $display("FAIL reset_others got nonzero outputs");
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({if4.busy, if4.done, if4.pat_o} !== 9'd0) begin
      errors++; $display("FAIL idle_after_reset got %h exp 0", {if4.busy, if4.done, if4.pat_o});
    end
  endtask

  task automatic test_pattern;
    logic [6:0] exp4 [4] = '{7'h01, 7'h60, 7'h30, 7'h18};
    if4.rsp_i = 16'h0000;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if4.pat_o !== exp4[i] || if4.busy !== 1'b1 || if4.done !== 1'b0) begin
        errors++; $display("FAIL pattern_%0d got pat %h busy %b done %b exp pat %h busy 1 done 0",
                           i, if4.pat_o, if4.busy, if4.done, exp4[i]);
      end
      tick();
    end
    checks++;
    if (if4.done !== 1'b1 || if4.busy !== 1'b0 || if4.pat_o !== 7'h00 ||
        if4.sig_o !== 16'h0000 || if4.pass !== 1'b1) begin
      errors++; $display("FAIL pattern_done got done %b busy %b pat %h sig %h pass %b exp 1 0 00 0000 1",
                         if4.done, if4.busy, if4.pat_o, if4.sig_o, if4.pass);
    end
  endtask

  task automatic test_misr;
    if2.rsp_i = 16'h0001;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    checks++;
    if (if2.sig_o !== 16'h0000 || if2.busy !== 1'b1) begin
      errors++; $display("FAIL misr_c0 got sig %h busy %b exp 0000 1", if2.sig_o, if2.busy);
    end
    tick();
    checks++;
    if (if2.sig_o !== 16'h0001 || if2.pass !== 1'b0 || if2.busy !== 1'b1) begin
      errors++; $display("FAIL misr_c1 got sig %h pass %b busy %b exp 0001 0 1", if2.sig_o, if2.pass, if2.busy);
    end
    tick();
    checks++;
    if (if2.sig_o !== 16'hB401 || if2.done !== 1'b1 || if2.pass !== 1'b1) begin
      errors++; $display("FAIL misr_done got sig %h done %b pass %b exp B401 1 1", if2.sig_o, if2.done, if2.pass);
    end
    tick();
    checks++;
    if (if2.sig_o !== 16'hB401 || if2.done !== 1'b1) begin
      errors++; $display("FAIL misr_frozen got sig %h done %b exp B401 1", if2.sig_o, if2.done);
    end
  endtask

  task automatic test_long_run;
    int n;
    n = 0;
    if100.rsp_i = 16'h0000;
    if100.start = 1'b1;
    tick();
    if100.start = 1'b0;
    while (if100.busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 100) begin
      errors++; $display("FAIL long_busy_cycles got %0d exp 100", n);
    end
    checks++;
    if (if100.done !== 1'b1 || if100.sig_o !== 16'h0000 || if100.pass !== 1'b1) begin
      errors++; $display("FAIL long_done got done %b sig %h pass %b exp 1 0000 1", if100.done, if100.sig_o, if100.pass);
    end
  endtask

  task automatic test_abort;
    if4.rsp_i = 16'h00FF;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    checks++;
    if (if4.pat_o !== 7'h30 || if4.sig_o !== 16'hB480) begin
      errors++; $display("FAIL abort_pre got pat %h sig %h exp 30 B480", if4.pat_o, if4.sig_o);
    end
    if4.abort = 1'b1;
    tick();
    if4.abort = 1'b0;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.sig_o !== 16'h0000 || if4.pat_o !== 7'h00) begin
      errors++; $display("FAIL abort got busy %b done %b sig %h pat %h exp 0 0 0000 00",
                         if4.busy, if4.done, if4.sig_o, if4.pat_o);
    end
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    if4.abort = 1'b1;
    if4.start = 1'b1;
    tick();
    if4.abort = 1'b0;
    if4.start = 1'b0;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.sig_o !== 16'h0000 || if4.pat_o !== 7'h00) begin
      errors++; $display("FAIL abort_with_start got busy %b done %b sig %h pat %h exp 0 0 0000 00",
                         if4.busy, if4.done, if4.sig_o, if4.pat_o);
    end
    tick();
    checks++;
    if (if4.busy !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle got busy %b exp 0", if4.busy);
    end
    // start inside a run must not restart the sequence
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    checks++;
    if (if4.pat_o !== 7'h30 || if4.busy !== 1'b1) begin
      errors++; $display("FAIL start_in_run got pat %h busy %b exp 30 1", if4.pat_o, if4.busy);
    end
    tick();
    tick();
    checks++;
    if (if4.done !== 1'b1) begin
      errors++; $display("FAIL start_in_run_done got done %b exp 1", if4.done);
    end
  endtask

  task automatic test_reset_midrun;
    if4.rsp_i = 16'h00FF;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (if4.pat_o !== 7'h00 || if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.sig_o !== 16'h0000) begin
      errors++; $display("FAIL async_reset got pat %h busy %b done %b sig %h exp 00 0 0 0000",
                         if4.pat_o, if4.busy, if4.done, if4.sig_o);
    end
    #1;
    rst = 1'b0;
    tick();
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    checks++;
    if (if4.pat_o !== 7'h01 || if4.busy !== 1'b1 || if4.sig_o !== 16'h0000) begin
      errors++; $display("FAIL restart_after_reset got pat %h busy %b sig %h exp 01 1 0000",
                         if4.pat_o, if4.busy, if4.sig_o);
    end
    tick();
    checks++;
    if (if4.pat_o !== 7'h60) begin
      errors++; $display("FAIL restart_second got pat %h exp 60", if4.pat_o);
    end
  endtask

  task automatic test_closed_loop;
    logic [6:0]  s;
    logic [15:0] m;
    s = 7'h01;
    m = 16'h0000;
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (if6.pat_o !== s) begin
        errors++; $display("FAIL loop_pat_%0d got %h exp %h", k, if6.pat_o, s);
      end
      m = ref_misr(m, mix_fn(s));
      s = ref_lfsr(s);
      tick();
    end
    checks++;
    if (if6.done !== 1'b1 || if6.sig_o !== m || if6.pass !== (m == 16'h0000)) begin
      errors++; $display("FAIL loop_sig got done %b sig %h pass %b exp 1 %h %b",
                         if6.done, if6.sig_o, if6.pass, m, (m == 16'h0000));
    end
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    checks++;
    if (if6.sig_o !== 16'h0000 || if6.pat_o !== 7'h01) begin
      errors++; $display("FAIL loop_rerun_clear got sig %h pat %h exp 0000 01", if6.sig_o, if6.pat_o);
    end
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (if6.done !== 1'b1 || if6.sig_o !== m) begin
      errors++; $display("FAIL loop_rerun got done %b sig %h exp 1 %h", if6.done, if6.sig_o, m);
    end
  endtask

  initial begin
    if4.start = 1'b0;   if4.abort = 1'b0;   if4.rsp_i = '0;
    if2.start = 1'b0;   if2.abort = 1'b0;   if2.rsp_i = '0;
    if100.start = 1'b0; if100.abort = 1'b0; if100.rsp_i = '0;
    if6.start = 1'b0;   if6.abort = 1'b0;
    test_reset();
    test_pattern();
    test_misr();
    test_long_run();
    test_abort();
    test_reset_midrun();
    test_closed_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
